// File: rtl/iterative_divider.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Operands are captured on start. Each CALC cycle retires one quotient bit.
// A single FIX cycle applies the sign correction and the divide-by-zero and
// signed-overflow results, then pulses done. Latency is fixed for all operands.
module iterative_divider #(
   parameter int dataWidth  = 32,
   parameter int countWidth = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signedOp,
   input  logic [dataWidth-1:0] dividend,
   input  logic [dataWidth-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [dataWidth-1:0] quotient,
   output logic [dataWidth-1:0] remainder,
   output logic                 divByZero
);

   localparam logic [countWidth-1:0] COUNT_INIT = countWidth'(dataWidth);
   localparam logic [countWidth-1:0] COUNT_ONE  = countWidth'(1);
   localparam logic [dataWidth-1:0]  MIN_SIGNED = {1'b1, {(dataWidth-1){1'b0}}};
   localparam logic [dataWidth-1:0]  ALL_ONES   = {dataWidth{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   // Two's-complement magnitude, taken only for signed operations.
   function automatic logic [dataWidth-1:0] magnitude(
      input logic [dataWidth-1:0] value,
      input logic                 is_signed
   );
      if (is_signed && value[dataWidth-1]) begin
         return -value;
      end
      return value;
   endfunction

   state_t                state_q, state_d;
   logic [countWidth-1:0] count_q, count_d;
   logic [dataWidth-1:0]  rem_q, rem_d;
   logic [dataWidth-1:0]  quo_q, quo_d;
   logic [dataWidth-1:0]  div_q, div_d;
   logic [dataWidth-1:0]  orig_dvd_q, orig_dvd_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  zero_div_q, zero_div_d;
   logic                  overflow_q, overflow_d;
   logic [dataWidth-1:0]  quotient_q, quotient_d;
   logic [dataWidth-1:0]  remainder_q, remainder_d;
   logic                  div_by_zero_q, div_by_zero_d;
   logic                  done_q, done_d;

   logic [dataWidth:0]    rem_shift;
   logic [dataWidth-1:0]  rem_trial;
   logic                  step_fits;
   logic [dataWidth-1:0]  quo_shift;
   logic [dataWidth-1:0]  quo_signed;
   logic [dataWidth-1:0]  rem_signed;

   // One restoring step: shift the next dividend bit into the partial
   // remainder and trial-subtract the divisor magnitude.
   always_comb begin
      rem_shift = {rem_q, quo_q[dataWidth-1]};
      quo_shift = {quo_q[dataWidth-2:0], 1'b0};
      step_fits = (rem_shift >= {1'b0, div_q});
      rem_trial = rem_shift[dataWidth-1:0] - div_q;
   end

   // Sign correction of the magnitude result, used in the FIX cycle.
   always_comb begin
      quo_signed = neg_quo_q ? -quo_q : quo_q;
      rem_signed = neg_rem_q ? -rem_q : rem_q;
   end

   // Next-state and datapath control for the IDLE/CALC/FIX sequence.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      div_d         = div_q;
      orig_dvd_d    = orig_dvd_q;
      neg_quo_d     = neg_quo_q;
      neg_rem_d     = neg_rem_q;
      zero_div_d    = zero_div_q;
      overflow_d    = overflow_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      done_d        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CALC;
               count_d    = COUNT_INIT;
               rem_d      = '0;
               quo_d      = magnitude(dividend, signedOp);
               div_d      = magnitude(divisor, signedOp);
               orig_dvd_d = dividend;
               neg_quo_d  = signedOp & (dividend[dataWidth-1] ^ divisor[dataWidth-1]);
               neg_rem_d  = signedOp & dividend[dataWidth-1];
               zero_div_d = (divisor == '0);
               overflow_d = signedOp && (dividend == MIN_SIGNED) && (divisor == ALL_ONES);
            end
         end

         CALC: begin
            if (step_fits) begin
               rem_d = rem_trial;
               quo_d = quo_shift | {{(dataWidth-1){1'b0}}, 1'b1};
            end else begin
               rem_d = rem_shift[dataWidth-1:0];
               quo_d = quo_shift;
            end
            count_d = count_q - COUNT_ONE;
            if (count_q == COUNT_ONE) begin
               state_d = FIX;
            end
         end

         FIX: begin
            if (zero_div_q) begin
               quotient_d    = ALL_ONES;
               remainder_d   = orig_dvd_q;
               div_by_zero_d = 1'b1;
            end else if (overflow_q) begin
               quotient_d    = MIN_SIGNED;
               remainder_d   = '0;
               div_by_zero_d = 1'b0;
            end else begin
               quotient_d    = quo_signed;
               remainder_d   = rem_signed;
               div_by_zero_d = 1'b0;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset; reset also aborts
   // an operation in flight without issuing done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         div_q         <= '0;
         orig_dvd_q    <= '0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         zero_div_q    <= 1'b0;
         overflow_q    <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         div_q         <= div_d;
         orig_dvd_q    <= orig_dvd_d;
         neg_quo_q     <= neg_quo_d;
         neg_rem_q     <= neg_rem_d;
         zero_div_q    <= zero_div_d;
         overflow_q    <= overflow_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
         done_q        <= done_d;
      end
   end

   // busy covers CALC and FIX, so it is already low in the done cycle.
   always_comb begin
      busy      = (state_q != IDLE);
      done      = done_q;
      quotient  = quotient_q;
      remainder = remainder_q;
      divByZero = div_by_zero_q;
   end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_iterative_divider;

   localparam int W = 32;
   localparam logic [W-1:0] MIN_S = 32'h8000_0000;
   localparam logic [W-1:0] ONES  = 32'hFFFF_FFFF;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         signedOp;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         divByZero;

   int checkCount = 0;
   int errorCount = 0;

   iterative_divider #(
      .dataWidth (W),
      .countWidth(6)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .signedOp (signedOp),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quotient (quotient),
      .remainder(remainder),
      .divByZero(divByZero)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard stop in case the stimulus itself gets stuck.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: RISC-V M-extension division using plain arithmetic.
   function automatic void refDiv(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      longint sa;
      longint sb;
      longint tq;
      longint tr;
      z = 1'b0;
      if (b == 0) begin
         q = ONES;
         r = a;
         z = 1'b1;
      end else if (s && a == MIN_S && b == ONES) begin
         q = MIN_S;
         r = '0;
      end else if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         tq = sa / sb;
         tr = sa % sb;
         q = tq[W-1:0];
         r = tr[W-1:0];
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Present operands with start for one edge, then scramble the inputs.
   task automatic startOp(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      signedOp = s;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      signedOp = 1'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Wait (bounded) for done; optionally pulse start with 50/5 at cycle glitchAt.
   task automatic waitDone(input string tag, input logic [W-1:0] expQ, input logic [W-1:0] expR,
                           input logic expZ, input int glitchAt);
      int n = 0;
      int busyCycles = 0;
      while (done !== 1'b1 && n < 200) begin
         if (busy === 1'b1) busyCycles++;
         if (n == glitchAt) begin
            start    = 1'b1;
            signedOp = 1'b0;
            dividend = 50;
            divisor  = 5;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      checkOutput({tag, " latency"}, n, W + 1);
      checkOutput({tag, " busyCycles"}, busyCycles, W + 1);
      checkOutput({tag, " busyInDone"}, busy, 0);
      checkOutput({tag, " quotient"}, quotient, expQ);
      checkOutput({tag, " remainder"}, remainder, expR);
      checkOutput({tag, " divByZero"}, divByZero, expZ);
   endtask

   task automatic applyStimulus(input string tag, input logic s, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] expQ,
                                input logic [W-1:0] expR, input logic expZ);
      startOp(s, a, b);
      waitDone(tag, expQ, expR, expZ, -1);
      @(negedge clk);
      checkOutput({tag, " donePulse"}, done, 0);
      checkOutput({tag, " heldQ"}, quotient, expQ);
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      logic         s;
      int           doneSeen;

      reset    = 1'b1;
      start    = 1'b0;
      signedOp = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset quotient", quotient, 0);
      checkOutput("reset remainder", remainder, 0);
      checkOutput("reset divByZero", divByZero, 0);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus("u100/7", 1'b0, 100, 7, 14, 2, 1'b0);
      applyStimulus("s-7/2", 1'b1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      applyStimulus("s7/-2", 1'b1, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 1'b0);
      applyStimulus("u/0", 1'b0, 32'h1234_5678, 0, ONES, 32'h1234_5678, 1'b1);
      applyStimulus("s/0", 1'b1, 32'h1234_5678, 0, ONES, 32'h1234_5678, 1'b1);
      applyStimulus("sOvf", 1'b1, MIN_S, ONES, MIN_S, 0, 1'b0);
      applyStimulus("uOvfOps", 1'b0, MIN_S, ONES, 0, MIN_S, 1'b0);

      startOp(1'b0, 1000, 3);
      waitDone("startWhileBusy", 333, 1, 1'b0, 5);
      startOp(1'b0, 50, 5);
      waitDone("backToBack", 10, 0, 1'b0, -1);

      startOp(1'b0, 1000, 3);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort quotient", quotient, 0);
      checkOutput("abort remainder", remainder, 0);
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
      end
      checkOutput("abort noDone", doneSeen, 0);
      applyStimulus("after9/3", 1'b0, 9, 3, 3, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 6))
            0: b = '0;
            1: b = ONES;
            2: b = $urandom_range(1, 15);
            3: begin a = MIN_S; b = ONES; end
            4: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         refDiv(s, a, b, q, r, z);
         applyStimulus($sformatf("rand%0d", i), s, a, b, q, r, z);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
